// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_e;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 16;

  function automatic logic load_use_hit(input logic       ex_mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [width-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {width{1'b1}})) begin
      cnt <= cnt + width'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze control for a 5-stage pipeline with a bounded memory wait.
// Outputs are decoded combinationally from state and current inputs.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             EX_mem_read,
  input  logic [4:0]       EX_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_stats,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             flush,
  output logic             ID_EX_bubble,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hazard_state_e     state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic              timeout;

  assign load_use  = load_use_hit(EX_mem_read, EX_rt, ID_rs, ID_rt);
  assign mem_stall = mem_req && !mem_ready;
  assign timeout   = (state == MEM_WAIT) && mem_stall && (wait_cnt == WAIT_LAST);

  // A timed-out wait releases everything for one cycle so the pipe can drain.
  always_comb begin
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    flush        = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (rst) begin
      if (timeout) begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
      end else if (mem_stall) begin
        pipe_freeze = 1'b1;
      end else if (load_use) begin
        ID_EX_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        flush       = branch_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (timeout) begin
            state   <= RUN;
            mem_err <= 1'b1;
          end else if (!mem_stall) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.width(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_stats),
    .inc (!pc_write),
    .cnt (stall_cnt)
  );

  sat_counter #(.width(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_stats),
    .inc (flush),
    .cnt (flush_cnt)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the maximum number of cycles spent in MEM_WAIT before abort.
REQ-002 Parameter CNT_W, default 16, is the width of the statistics counters.
REQ-003 clk  in  1  single clock, all state updates on posedge.
REQ-004 rst  in  1  synchronous reset, active-low.
REQ-005 ID_rs, ID_rt  in  5 each  source register fields of the instruction in ID.
REQ-006 EX_mem_read  in  1  instruction in EX is a load.
REQ-007 EX_rt  in  5  destination register of the EX load.
REQ-008 branch_taken  in  1  ID resolved a taken branch or jump.
REQ-009 mem_req, mem_ready  in  1 each  MEM-stage data access pending / data memory done.
REQ-010 clr_stats  in  1  synchronous clear of the statistics counters.
REQ-011 pc_write  out  1  PC load enable.
REQ-012 IF_ID_write  out  1  IF/ID register write enable.
REQ-013 flush  out  1  IF/ID flush (zero instruction and pc).
REQ-014 ID_EX_bubble  out  1  insert NOP into ID/EX.
REQ-015 pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-016 mem_err  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-018 The FSM SHALL have two states, RUN and MEM_WAIT; the outputs SHALL be Mealy, meaning they are decoded from the state and the current-cycle inputs.
REQ-019 Load-use hazard = EX_mem_read && EX_rt!=0 && (EX_rt==ID_rs || EX_rt==ID_rt).
REQ-020 Memory stall = mem_req && !mem_ready.
REQ-021 Priority SHALL be memory stall > load-use > branch_taken > normal.
REQ-022 Normal: pc_write=1, IF_ID_write=1, flush=0, ID_EX_bubble=0, pipe_freeze=0.
REQ-023 Memory stall (either state): pc_write=0, IF_ID_write=0, flush=0, ID_EX_bubble=0, pipe_freeze=1.
REQ-024 Load-use: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, flush=0; this lasts exactly one cycle, because the load then leaves EX.
REQ-025 Load-use together with branch_taken: no flush; the branch is re-evaluated next cycle.
REQ-026 branch_taken alone: pc_write=1, IF_ID_write=1, flush=1.
REQ-027 flush SHALL never be asserted while IF_ID_write=0.
REQ-028 RUN->MEM_WAIT on a memory stall.
REQ-029 wait_cnt SHALL clear on entry to MEM_WAIT and increment each cycle in MEM_WAIT.
REQ-030 MEM_WAIT->RUN when mem_ready=1; that cycle's outputs follow REQ-021..026.
REQ-031 MEM_WAIT->RUN when wait_cnt==MEM_TIMEOUT-1 with mem_ready=0; that cycle mem_err SHALL set and the freeze SHALL be released (normal outputs).
REQ-032 mem_err SHALL clear only on reset.
REQ-033 stall_cnt SHALL increment in each cycle with pc_write=0, and flush_cnt in each cycle with flush=1.
REQ-034 Both statistics counters SHALL saturate at all-ones and never wrap.
REQ-035 clr_stats SHALL clear both counters and take precedence over an increment in the same cycle.

Reset
REQ-036 With rst=0 at posedge, the next state SHALL be: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
REQ-037 While rst=0, the outputs SHALL be pc_write=0, IF_ID_write=0, flush=0, ID_EX_bubble=0, pipe_freeze=0, and the counters SHALL not increment.
REQ-038 Reset asserted mid-MEM_WAIT SHALL abort the wait without setting mem_err.

Structure
REQ-039 The state enum, the MEM_TIMEOUT default and the CNT_W default SHALL live in shared package hazard_pkg.
REQ-040 One sub-module, sat_counter (parameter width; inputs clr, inc), SHALL be instantiated twice for stall_cnt and flush_cnt.

Verification
REQ-041 Load-use: EX_mem_read=1, EX_rt=5, ID_rs=5 for 1 cycle -> pc_write=0, IF_ID_write=0, ID_EX_bubble=1 for 1 cycle; stall_cnt=1.
REQ-042 EX_rt=0 case: EX_rt=0=ID_rs with EX_mem_read=1 -> normal outputs, no bubble.
REQ-043 Branch: branch_taken=1 alone -> flush=1, IF_ID_write=1, flush_cnt=1; with a simultaneous load-use -> flush=0, bubble=1.
REQ-044 Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> pipe_freeze=1 for 3 cycles, stall_cnt=3, state returns to RUN.
REQ-045 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after 4 wait cycles, freeze released; rst=0 clears mem_err.
REQ-046 Saturation/clear: CNT_W=2, 5 stall cycles -> stall_cnt=3; clr_stats with a stall in the same cycle -> stall_cnt=0.
